// File: rtl/hazard_freeze_controller.sv
// Hazard stall detection and multi-cycle SRAM freeze sequencing for the 5-stage MIPS pipeline.
// Optional stall/freeze performance counters: define STALL_PERF_CNT_EN.
module hazard_freeze_controller #(
    parameter int SRAM_WAIT_CYCLES = 5,
    parameter int REG_ADDR_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] ST_Src,
    input  logic                  ID_MEM_W_EN,
    input  logic [REG_ADDR_W-1:0] EXE_Dest,
    input  logic                  EXE_WB_EN,
    input  logic                  EXE_MEM_R_EN,
    input  logic [REG_ADDR_W-1:0] MEM_Dest,
    input  logic                  MEM_WB_EN,
    input  logic                  MEM_R_EN,
    input  logic                  MEM_W_EN,
    input  logic                  forward_en,
`ifdef STALL_PERF_CNT_EN
    input  logic                  perf_clr,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           freeze_cycles,
`endif
    output logic                  hazard_stall,
    output logic                  pipe_freeze,
    output logic                  mem_ready
);

    localparam int CNT_W = (SRAM_WAIT_CYCLES > 2) ? $clog2(SRAM_WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (SRAM_WAIT_CYCLES > 2) ? CNT_W'(SRAM_WAIT_CYCLES - 3) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             mem_access;
    logic             exe_hit;
    logic             mem_hit;
    logic             raw_hazard;

    // R0 is hardwired to zero, so it never carries a dependency.
    function automatic logic addr_match(input logic [REG_ADDR_W-1:0] src,
                                        input logic [REG_ADDR_W-1:0] dest,
                                        input logic                  wb_en);
        return wb_en && (dest != '0) && (src == dest);
    endfunction

    always_comb begin
        exe_hit = addr_match(src1, EXE_Dest, EXE_WB_EN)
                | (two_src     & addr_match(src2,   EXE_Dest, EXE_WB_EN))
                | (ID_MEM_W_EN & addr_match(ST_Src, EXE_Dest, EXE_WB_EN));
        mem_hit = addr_match(src1, MEM_Dest, MEM_WB_EN)
                | (two_src     & addr_match(src2,   MEM_Dest, MEM_WB_EN))
                | (ID_MEM_W_EN & addr_match(ST_Src, MEM_Dest, MEM_WB_EN));
        raw_hazard = forward_en ? (exe_hit & EXE_MEM_R_EN) : (exe_hit | mem_hit);
    end

    assign mem_access = MEM_R_EN | MEM_W_EN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_access) begin
                        if (SRAM_WAIT_CYCLES == 2) begin
                            state <= DONE;
                        end else begin
                            counter <= CNT_LOAD;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (counter == '0) state <= DONE;
                    else               counter <= counter - CNT_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The IDLE freeze follows mem_access directly; rst masks it so reset clears outputs at once.
    always_comb begin
        pipe_freeze = 1'b0;
        unique case (state)
            IDLE:    pipe_freeze = mem_access;
            WAIT:    pipe_freeze = 1'b1;
            DONE:    pipe_freeze = 1'b0;
            default: pipe_freeze = 1'b0;
        endcase
        if (rst) pipe_freeze = 1'b0;
    end

    assign mem_ready    = (state == DONE);
    assign hazard_stall = raw_hazard & ~pipe_freeze & ~rst;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
        end else begin
            if (hazard_stall && (stall_cycles != '1))  stall_cycles  <= stall_cycles + 32'd1;
            if (pipe_freeze  && (freeze_cycles != '1)) freeze_cycles <= freeze_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_freeze_controller.sv
// Self-checking bench for hazard_freeze_controller: table-driven hazard vectors plus
// hand-written SRAM access, back-to-back and mid-access reset sequences.
module tb_hazard_freeze_controller;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] src1, src2, ST_Src, EXE_Dest, MEM_Dest;
    logic         two_src, ID_MEM_W_EN, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
    logic         MEM_R_EN, MEM_W_EN, forward_en;
    logic         hazard_stall, pipe_freeze, mem_ready;
`ifdef STALL_PERF_CNT_EN
    logic         perf_clr = 1'b0;
    logic [31:0]  stall_cycles, freeze_cycles;
`endif

    hazard_freeze_controller #(.SRAM_WAIT_CYCLES(5), .REG_ADDR_W(W)) dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .two_src(two_src),
        .ST_Src(ST_Src), .ID_MEM_W_EN(ID_MEM_W_EN),
        .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
        .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .forward_en(forward_en),
`ifdef STALL_PERF_CNT_EN
        .perf_clr(perf_clr), .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles),
`endif
        .hazard_stall(hazard_stall), .pipe_freeze(pipe_freeze), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] src1, src2, st_src, exe_dest, mem_dest;
        logic         two_src, id_mem_w_en, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd;
        logic         exp_stall;
    } vec_t;

    typedef struct {
        string name;
        logic  freeze, ready, stall;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic ts,
                                input logic [W-1:0] st, input logic sw,
                                input logic [W-1:0] ed, input logic ew, input logic er,
                                input logic [W-1:0] md, input logic mw, input logic fw,
                                input logic es);
        vec_t v;
        v.src1 = s1; v.src2 = s2; v.two_src = ts; v.st_src = st; v.id_mem_w_en = sw;
        v.exe_dest = ed; v.exe_wb_en = ew; v.exe_mem_r_en = er;
        v.mem_dest = md; v.mem_wb_en = mw; v.fwd = fw; v.exp_stall = es;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // One cycle: drive after the falling edge, queue the expectation, check 1 ns later.
    task automatic step(input string nm, input vec_t v, input logic r, input logic mr,
                        input logic mw, input logic ef, input logic er, input logic es);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r;
        src1 = v.src1; src2 = v.src2; two_src = v.two_src;
        ST_Src = v.st_src; ID_MEM_W_EN = v.id_mem_w_en;
        EXE_Dest = v.exe_dest; EXE_WB_EN = v.exe_wb_en; EXE_MEM_R_EN = v.exe_mem_r_en;
        MEM_Dest = v.mem_dest; MEM_WB_EN = v.mem_wb_en; forward_en = v.fwd;
        MEM_R_EN = mr; MEM_W_EN = mw;
        e.name = nm; e.freeze = ef; e.ready = er; e.stall = es;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        cmp({got.name, ".pipe_freeze"}, pipe_freeze, got.freeze);
        cmp({got.name, ".mem_ready"}, mem_ready, got.ready);
        cmp({got.name, ".hazard_stall"}, hazard_stall, got.stall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t lu;
        vec_t quiet;
        //                s1 s2 ts st sw ed ew er md mw fw exp
        vecs[0]  = mk(3, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 1); // load-use
        vecs[1]  = mk(3, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0); // forwardable ALU result
        vecs[2]  = mk(1, 7, 1, 0, 0, 0, 0, 0, 7, 1, 0, 1); // no-fwd src2 vs MEM
        vecs[3]  = mk(1, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0); // src2 not read
        vecs[4]  = mk(1, 7, 0, 7, 1, 0, 0, 0, 7, 1, 0, 1); // store data vs MEM
        vecs[5]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0); // R0 never hazards
        vecs[6]  = mk(4, 0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0); // MEM dep forwarded
        vecs[7]  = mk(3, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 0); // load without WB_EN
        vecs[8]  = mk(1, 9, 1, 0, 0, 9, 1, 1, 0, 0, 1, 1); // load-use on src2
        vecs[9]  = mk(6, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1); // no-fwd EXE dep
        vecs[10] = mk(5, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0); // MEM_WB_EN=0
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // R0 vs MEM, no-fwd
        vecs[12] = mk(1, 2, 0, 8, 0, 8, 1, 1, 0, 0, 1, 0); // store src unchecked

        lu    = mk(3, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 1);
        quiet = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;

        // Reset: outputs low even with an access request and a live hazard
        step("reset", lu, 1, 1, 0, 0, 0, 0);
        step("reset_hold", lu, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), vecs[i], 0, 0, 0, 0, 0, vecs[i].exp_stall);

        // SRAM read with a held load-use hazard; request changes in WAIT/DONE are ignored
        step("rd_c0", lu, 0, 1, 0, 1, 0, 0);
        step("rd_c1", lu, 0, 1, 0, 1, 0, 0);
        step("rd_c2", lu, 0, 0, 0, 1, 0, 0);
        step("rd_c3", lu, 0, 0, 0, 1, 0, 0);
        step("rd_c4", lu, 0, 1, 0, 0, 1, 1);
        // Back-to-back write starts in the cycle right after DONE
        step("b2b_c0", quiet, 0, 0, 1, 1, 0, 0);
        step("b2b_c1", quiet, 0, 0, 0, 1, 0, 0);
        step("b2b_c2", quiet, 0, 0, 0, 1, 0, 0);
        step("b2b_c3", quiet, 0, 0, 0, 1, 0, 0);
        step("b2b_c4", quiet, 0, 0, 0, 0, 1, 0);
        step("idle_after", lu, 0, 0, 0, 0, 0, 1);

        // Reset in WAIT aborts the access; next access takes the full duration
        step("abort_c0", lu, 0, 1, 0, 1, 0, 0);
        step("abort_c1", lu, 0, 1, 0, 1, 0, 0);
        step("abort_rst", lu, 1, 1, 0, 0, 0, 0);
        step("abort_rst2", lu, 1, 1, 0, 0, 0, 0);
        step("abort_rel", lu, 0, 0, 0, 0, 0, 1);
        step("wr_c0", quiet, 0, 0, 1, 1, 0, 0);
        step("wr_c1", quiet, 0, 0, 0, 1, 0, 0);
        step("wr_c2", quiet, 0, 0, 0, 1, 0, 0);
        step("wr_c3", quiet, 0, 0, 0, 1, 0, 0);
        step("wr_c4", quiet, 0, 0, 0, 0, 1, 0);
        step("wr_c5", quiet, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_freeze_controller.md
Name: hazard_freeze_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. Combines hazard stall detection with a multi-cycle SRAM access sequencer.
- Decides when the ID stage must stall because forwarding cannot resolve a dependency (load-use, or any dependency when forwarding is disabled).
- Freezes the whole pipeline while the MEM stage waits on SRAM.
- Drives the IF/ID/EXE/MEM/WB register enables alongside the forwarding unit.

Parameters:
- SRAM_WAIT_CYCLES, 5, total cycles one SRAM access occupies the MEM stage; legal range ≥2.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- src1  in  REG_ADDR_W  ID first source register
- src2  in  REG_ADDR_W  ID second source register
- two_src  in  1  ID instruction reads src2 as a register
- ST_Src  in  REG_ADDR_W  ID store-data source register
- ID_MEM_W_EN  in  1  ID instruction is a store
- EXE_Dest  in  REG_ADDR_W  EXE destination register
- EXE_WB_EN  in  1  EXE writes back
- EXE_MEM_R_EN  in  1  EXE instruction is a load
- MEM_Dest  in  REG_ADDR_W  MEM destination register
- MEM_WB_EN  in  1  MEM writes back
- MEM_R_EN  in  1  MEM stage performs an SRAM read
- MEM_W_EN  in  1  MEM stage performs an SRAM write
- forward_en  in  1  forwarding active (1) or bypassed (0)
- hazard_stall  out  1  hold PC and IF/ID, insert bubble into ID/EXE
- pipe_freeze  out  1  hold all pipeline registers
- mem_ready  out  1  SRAM data valid / write complete this cycle

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, counter=0.
  - hazard_stall=0, pipe_freeze=0, mem_ready=0 immediately, without waiting for a clock edge.
- Match definition: a source matches a destination when the addresses are equal, the destination is non-zero (R0 never creates a hazard) and the destination stage's WB_EN is 1.
- Sources checked:
  - src1: always.
  - src2: only when two_src=1.
  - ST_Src: only when ID_MEM_W_EN=1.
- raw_hazard, combinational:
  - forward_en=1: any checked source matches EXE_Dest AND EXE_MEM_R_EN=1.
  - forward_en=0: any checked source matches EXE_Dest or MEM_Dest.
- hazard_stall = raw_hazard & ~pipe_freeze. Freeze dominates; a stall is never reported while frozen.
- mem_access = MEM_R_EN | MEM_W_EN.
- FSM states: IDLE, WAIT, DONE. Transitions are on the rising clk edge.
  - IDLE:
    - pipe_freeze = mem_access (combinational).
    - If mem_access and SRAM_WAIT_CYCLES=2: go to DONE.
    - If mem_access and SRAM_WAIT_CYCLES>2: counter ← SRAM_WAIT_CYCLES-3, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - pipe_freeze=1.
    - If counter=0: go to DONE.
    - Otherwise counter ← counter-1.
  - DONE:
    - pipe_freeze=0, mem_ready=1; the pipeline advances on this edge.
    - Unconditionally go to IDLE.
- Access timing: an access occupies exactly SRAM_WAIT_CYCLES cycles, with freeze for the first SRAM_WAIT_CYCLES-1 and mem_ready in the last.
- mem_access is sampled only in IDLE. Changes while in WAIT or DONE are ignored.
- Back-to-back accesses: a new access seen in the IDLE cycle right after DONE starts immediately. There is no idle bubble.
- Mid-access reset: the FSM aborts to IDLE, and the access is discarded. After release, the next access takes the full SRAM_WAIT_CYCLES.
- Counter width: clog2(SRAM_WAIT_CYCLES).

Optional Feature:
- STALL_PERF_CNT_EN defined:
  - Adds input perf_clr (1b) and outputs stall_cycles (32b) and freeze_cycles (32b).
  - stall_cycles increments on each clk where hazard_stall=1; freeze_cycles increments on each clk where pipe_freeze=1.
  - Both counters saturate at 32'hFFFFFFFF.
  - Both clear on rst or on perf_clr=1 (synchronous); perf_clr has priority over increment.
- Not defined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load-use, forward_en=1: EXE_Dest=3, EXE_WB_EN=1, EXE_MEM_R_EN=1, src1=3 → hazard_stall=1 that cycle. Same with EXE_MEM_R_EN=0 → hazard_stall=0.
- No-forward path, forward_en=0: MEM_Dest=7, MEM_WB_EN=1, src2=7.
  - two_src=1 → hazard_stall=1.
  - two_src=0 → 0.
  - ST_Src=7 with ID_MEM_W_EN=1 → 1.
- R0: EXE_Dest=0, EXE_MEM_R_EN=1, src1=0, src2=0, two_src=1 → hazard_stall=0.
- SRAM read, SRAM_WAIT_CYCLES=5: MEM_R_EN=1 at cycle 0 → pipe_freeze=1 in cycles 0–3; cycle 4 gives pipe_freeze=0 and mem_ready=1; cycle 5 is IDLE.
- Reset in WAIT at cycle 2 → pipe_freeze and mem_ready go 0 before the next edge. After release, MEM_W_EN=1 → freeze for 4 cycles, mem_ready on the 5th.
- Load-use during freeze: raw hazard held through access cycles 0–4 → hazard_stall=0 in cycles 0–3. In cycle 4 (DONE, pipe_freeze=0) → hazard_stall=1.
